// File: rtl/rat_io_hub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rat_io_hub                                                    |
// | Purpose  : RAT CPU port-mapped I/O fabric: input mux, registered outputs |
// |            and pending/mask/ack interrupt controller.                    |
// |            Macro RAT_IO_READBACK_EN adds readback of output registers.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rat_io_hub #(
    parameter int         N_IN     = 4,
    parameter int         N_OUT    = 4,
    parameter int         N_IRQ    = 4,
    parameter logic [7:0] IN_BASE  = 8'h20,
    parameter logic [7:0] OUT_BASE = 8'h40,
    parameter logic [7:0] IRQ_BASE = 8'hF0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [7:0]         PORT_ID,
    input  logic [7:0]         OUT_PORT,
    input  logic               IO_STRB,
    output logic [7:0]         IN_PORT,
    input  logic [8*N_IN-1:0]  IN_DATA,
    output logic [8*N_OUT-1:0] OUT_DATA,
    output logic [N_OUT-1:0]   OUT_WE,
    input  logic [N_IRQ-1:0]   IRQ_IN,
    output logic               INTERRUPT
);

    localparam int c_in_lo  = int'(IN_BASE);
    localparam int c_in_hi  = c_in_lo + N_IN;
    localparam int c_out_lo = int'(OUT_BASE);
    localparam int c_out_hi = c_out_lo + N_OUT;
    localparam int c_irq_lo = int'(IRQ_BASE);
    localparam int c_irq_hi = c_irq_lo + 3;

    // Upper bounds are exclusive, so a range may end exactly at 8'hFF.
    localparam bit c_cfg_bad =
        (N_IN < 1) || (N_IN > 16) || (N_OUT < 1) || (N_OUT > 16) ||
        (N_IRQ < 1) || (N_IRQ > 8) ||
        (c_in_hi > 256) || (c_out_hi > 256) || (c_irq_hi > 256) ||
        ((c_in_lo < c_out_hi) && (c_out_lo < c_in_hi)) ||
        ((c_in_lo < c_irq_hi) && (c_irq_lo < c_in_hi)) ||
        ((c_out_lo < c_irq_hi) && (c_irq_lo < c_out_hi));

    if (c_cfg_bad) begin : g_cfg_err
        $error("rat_io_hub: port ranges overlap or exceed 8'hFF, or channel count out of range");
    end

    logic                r_strb_q;
    logic [7:0]          r_out_ch [N_OUT];
    logic [N_OUT-1:0]    r_out_we;
    logic [N_IRQ-1:0]    r_sync1;
    logic [N_IRQ-1:0]    r_sync2;
    logic [N_IRQ-1:0]    r_hist;
    logic [N_IRQ-1:0]    r_pending;
    logic [N_IRQ-1:0]    r_mask;
    logic                r_int;

    logic                w_commit;
    logic [N_OUT-1:0]    w_out_sel;
    logic                w_mask_wr;
    logic [N_IRQ-1:0]    w_ack_clr;
    logic [N_IRQ-1:0]    w_rise;
    logic [7:0]          w_rd_data;
    logic                w_rd_hit;

    // A strobe level spanning many fast clocks produces a single commit.
    always_comb begin
        w_commit  = IO_STRB & ~r_strb_q;
        w_out_sel = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_out_sel[j] = w_commit && (PORT_ID == OUT_BASE + 8'(j));
        end
        w_mask_wr = w_commit && (PORT_ID == IRQ_BASE + 8'd1);
        w_ack_clr = (w_commit && (PORT_ID == IRQ_BASE + 8'd2)) ? OUT_PORT[N_IRQ-1:0] : '0;
        w_rise    = r_sync2 & ~r_hist;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_strb_q  <= 1'b0;
            r_out_we  <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_hist    <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_int     <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                r_out_ch[j] <= 8'h00;
            end
        end else begin
            r_strb_q <= IO_STRB;
            r_out_we <= w_out_sel;
            for (int j = 0; j < N_OUT; j++) begin
                if (w_out_sel[j]) begin
                    r_out_ch[j] <= OUT_PORT;
                end
            end
            if (w_mask_wr) begin
                r_mask <= OUT_PORT[N_IRQ-1:0];
            end
            r_sync1   <= IRQ_IN;
            r_sync2   <= r_sync1;
            r_hist    <= r_sync2;
            // New edge is OR-ed after the clear so a coincident set survives the ack.
            r_pending <= (r_pending & ~w_ack_clr) | w_rise;
            r_int     <= |(r_pending & r_mask);
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        w_rd_hit  = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (!w_rd_hit && (PORT_ID == IN_BASE + 8'(i))) begin
                w_rd_data = IN_DATA[8*i +: 8];
                w_rd_hit  = 1'b1;
            end
        end
        if (!w_rd_hit && (PORT_ID == IRQ_BASE)) begin
            w_rd_data = 8'(r_pending);
            w_rd_hit  = 1'b1;
        end else if (!w_rd_hit && (PORT_ID == IRQ_BASE + 8'd1)) begin
            w_rd_data = 8'(r_mask);
            w_rd_hit  = 1'b1;
        end
`ifdef RAT_IO_READBACK_EN
        for (int j = 0; j < N_OUT; j++) begin
            if (!w_rd_hit && (PORT_ID == OUT_BASE + 8'(j))) begin
                w_rd_data = r_out_ch[j];
                w_rd_hit  = 1'b1;
            end
        end
`endif
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_out_pack
        assign OUT_DATA[8*j +: 8] = r_out_ch[j];
    end

    assign OUT_WE    = r_out_we;
    assign INTERRUPT = r_int;
    assign IN_PORT   = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_rat_io_hub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rat_io_hub                                                 |
// | Purpose  : scoreboard bench for rat_io_hub with a cycle reference model. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_rat_io_hub;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  PORT_ID;
    logic [7:0]  OUT_PORT;
    logic        IO_STRB;
    logic [7:0]  IN_PORT;
    logic [31:0] IN_DATA;
    logic [31:0] OUT_DATA;
    logic [3:0]  OUT_WE;
    logic [3:0]  IRQ_IN;
    logic        INTERRUPT;
    logic [7:0]  in_ch [4];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign IN_DATA = {in_ch[3], in_ch[2], in_ch[1], in_ch[0]};

    rat_io_hub dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .PORT_ID   (PORT_ID),
        .OUT_PORT  (OUT_PORT),
        .IO_STRB   (IO_STRB),
        .IN_PORT   (IN_PORT),
        .IN_DATA   (IN_DATA),
        .OUT_DATA  (OUT_DATA),
        .OUT_WE    (OUT_WE),
        .IRQ_IN    (IRQ_IN),
        .INTERRUPT (INTERRUPT)
    );

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] data;
        logic        intr;
    } exp_t;

    exp_t        exp_q [$];
    logic [7:0]  rd_id [$];
    logic [7:0]  rd_exp [$];
    string       chk_name [$];
    logic [31:0] chk_act [$];
    logic [31:0] chk_exp [$];

    // Reference model state: what the hub should hold after each edge.
    logic [7:0] m_out [4];
    logic [3:0] m_we, m_mask, m_pend, m_ack, m_rise;
    logic [3:0] m_s [3];
    logic       m_int, m_strb, m_commit, m_next_int;
    int         m_idx;
    exp_t       m_e;

    always @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < 4; k++) m_out[k] = 8'h00;
            for (int k = 0; k < 3; k++) m_s[k] = 4'h0;
            m_we = 4'h0; m_mask = 4'h0; m_pend = 4'h0; m_int = 1'b0; m_strb = 1'b0;
        end else begin
            m_commit   = IO_STRB && !m_strb;
            m_strb     = IO_STRB;
            m_we       = 4'h0;
            m_ack      = 4'h0;
            m_next_int = |(m_pend & m_mask);
            // m_s[0] = sample one edge ago, m_s[1] two ago, m_s[2] three ago
            m_rise     = m_s[1] & ~m_s[2];
            m_s[2] = m_s[1]; m_s[1] = m_s[0]; m_s[0] = IRQ_IN;
            if (m_commit) begin
                m_idx = int'(PORT_ID) - 'h40;
                if (m_idx >= 0 && m_idx < 4) begin
                    m_out[m_idx] = OUT_PORT;
                    m_we[m_idx]  = 1'b1;
                end else if (PORT_ID == 8'hF1) begin
                    m_mask = OUT_PORT[3:0];
                end else if (PORT_ID == 8'hF2) begin
                    m_ack = OUT_PORT[3:0];
                end
            end
            m_pend = (m_pend & ~m_ack) | m_rise;
            m_int  = m_next_int;
        end
        m_e.we   = m_we;
        m_e.data = {m_out[3], m_out[2], m_out[1], m_out[0]};
        m_e.intr = m_int;
        exp_q.push_back(m_e);
    end

    function automatic logic [7:0] model_read(input logic [7:0] id);
        int a;
        a = int'(id);
        if (a >= 'h20 && a < 'h24) return in_ch[a - 'h20];
        if (a == 'hF0) return {4'h0, m_pend};
        if (a == 'hF1) return {4'h0, m_mask};
`ifdef RAT_IO_READBACK_EN
        if (a >= 'h40 && a < 'h44) return m_out[a - 'h40];
`endif
        return 8'h00;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: actual=%08h required=%08h", nm, $time, act, expv);
        end
    endtask

    exp_t mon_e;
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cmp("out_we", 32'(OUT_WE), 32'(mon_e.we));
            cmp("out_data", OUT_DATA, mon_e.data);
            cmp("interrupt", 32'(INTERRUPT), 32'(mon_e.intr));
        end
        if (rd_id.size() > 0) begin
            cmp($sformatf("read_%02h", rd_id.pop_front()), 32'(IN_PORT), 32'(rd_exp.pop_front()));
        end
        while (chk_name.size() > 0) begin
            cmp(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        chk_name.push_back(nm);
        chk_act.push_back(act);
        chk_exp.push_back(expv);
    endtask

    task automatic rdx(input logic [7:0] id, input logic [7:0] expv);
        PORT_ID = id;
        rd_id.push_back(id);
        rd_exp.push_back(expv);
        tick();
    endtask

    task automatic rd(input logic [7:0] id);
        rdx(id, model_read(id));
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d, input int hold);
        int pulses;
        pulses   = 0;
        PORT_ID  = id;
        OUT_PORT = d;
        IO_STRB  = 1'b1;
        for (int k = 0; k < hold; k++) begin
            tick();
            pulses += $countones(OUT_WE);
        end
        IO_STRB = 1'b0;
        tick();
        pulses += $countones(OUT_WE);
        push_chk("we_pulses", 32'(pulses), (id >= 8'h40 && id <= 8'h43) ? 32'd1 : 32'd0);
    endtask

    logic [7:0] wr_ids [11] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'hF1, 8'hF2, 8'hF2, 8'h44, 8'h3F, 8'hF0, 8'h20};
    logic [7:0] rd_ids [12] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'hF0, 8'hF1, 8'hF2, 8'h40, 8'h43, 8'h24, 8'h1F, 8'hF3};
    logic [3:0] lat;

    initial begin
        RESET = 1'b1; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00; IRQ_IN = 4'h0;
        for (int k = 0; k < 4; k++) in_ch[k] = 8'h00;
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        push_chk("reset_out_data", OUT_DATA, 32'h0);
        rdx(8'hF0, 8'h00);
        rdx(8'hF1, 8'h00);

        wr(8'h41, 8'hA5, 4);
        push_chk("ch1_only", OUT_DATA, 32'h0000_A500);

        in_ch[0] = 8'h11; in_ch[1] = 8'h77; in_ch[2] = 8'h3C; in_ch[3] = 8'hE1;
        rdx(8'h22, 8'h3C);
        rdx(8'h99, 8'h00);

        wr(8'hF1, 8'h01, 1);
        IRQ_IN[0] = 1'b1;
        lat = 4'h0;
        for (int e = 0; e < 4; e++) begin
            tick();
            lat[e] = INTERRUPT;
        end
        push_chk("irq_latency", 32'(lat), 32'h8);
        wr(8'hF2, 8'h01, 1);
        push_chk("ack_clears_int", 32'(INTERRUPT), 32'd0);
        repeat (6) tick();
        push_chk("held_no_reassert", 32'(INTERRUPT), 32'd0);
        rdx(8'hF0, 8'h00);
        IRQ_IN[0] = 1'b0;

        wr(8'hF1, 8'h00, 1);
        IRQ_IN[2] = 1'b1;
        repeat (2) tick();
        IRQ_IN[2] = 1'b0;
        repeat (4) tick();
        rdx(8'hF0, 8'h04);
        push_chk("masked_no_int", 32'(INTERRUPT), 32'd0);
        wr(8'hF1, 8'h04, 1);
        push_chk("unmask_int", 32'(INTERRUPT), 32'd1);
        wr(8'hF2, 8'hFF, 1);

        // Rise of IRQ_IN[1] reaches the pending register on the ack commit edge.
        IRQ_IN[1] = 1'b1;
        repeat (2) tick();
        PORT_ID = 8'hF2; OUT_PORT = 8'h02; IO_STRB = 1'b1;
        tick();
        IO_STRB = 1'b0;
        tick();
        rdx(8'hF0, 8'h02);
        IRQ_IN[1] = 1'b0;
        wr(8'hF2, 8'hFF, 1);
        wr(8'hF1, 8'h00, 1);

        wr(8'h40, 8'h5A, 2);
`ifdef RAT_IO_READBACK_EN
        rdx(8'h40, 8'h5A);
`else
        rdx(8'h40, 8'h00);
`endif
        rdx(8'hF2, 8'h00);

        RESET = 1'b1; PORT_ID = 8'h43; OUT_PORT = 8'h77; IO_STRB = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
        repeat (3) tick();
        IO_STRB = 1'b0;
        tick();
        push_chk("rst_hold_commit", OUT_DATA, 32'h7700_0000);

        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 3))
                0: wr(wr_ids[$urandom_range(0, 10)], 8'($urandom), int'($urandom_range(1, 3)));
                1: rd(rd_ids[$urandom_range(0, 11)]);
                2: begin IRQ_IN = 4'($urandom); tick(); end
                default: begin in_ch[$urandom_range(0, 3)] = 8'($urandom); tick(); end
            endcase
        end

        repeat (3) @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
